stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter: STACK_WORDS, default 16'hF400, number of words in the stack region 0x0000..0xF3FF.
REQ-002 Port: CLK  input  1  rising-edge clock.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: push_req  input  1  single-cycle push request, sampled only in IDLE.
REQ-005 Port: pop_req  input  1  single-cycle pop request, sampled only in IDLE.
REQ-006 Port: flush  input  1  empties the stack, sampled only in IDLE.
REQ-007 Port: push_data  input  16  word to push, sampled with push_req.
REQ-008 Port: mem_rdata  input  16  memory read data, valid one cycle after mem_re.
REQ-009 Port: mem_addr  output  16  memory address.
REQ-010 Port: mem_wdata  output  16  memory write data.
REQ-011 Port: mem_we, mem_re  output  1 each  memory write and read strobes.
REQ-012 Port: pop_data  output  16  last popped word, held until the next pop completes.
REQ-013 Port: SP  output  16  current stack pointer.
REQ-014 Port: depth  output  16  number of occupied words.
REQ-015 Port: busy, done  output  1 each  operation in progress; one-cycle completion pulse.
REQ-016 Port: overflow, underflow  output  1 each  one-cycle rejected-request pulses.

Function
REQ-017 FSM states SHALL be IDLE, PUSH_WR, POP_RD and POP_WAIT; busy SHALL be high in every state except IDLE.
REQ-018 Pointer step rule: dec(0x0000)=0xF3FF; inc(0xF3FF)=0x0000; otherwise ±1 modulo 2^16.
REQ-019 IDLE with push_req and depth<STACK_WORDS SHALL latch push_data, set SP<=dec(SP) and depth<=depth+1, and go to PUSH_WR.
REQ-020 PUSH_WR SHALL drive mem_we=1, mem_addr=SP and mem_wdata=the latched word; it SHALL pulse done and return to IDLE.
REQ-021 IDLE with pop_req (and no accepted push) and depth>0 SHALL go to POP_RD.
REQ-022 POP_RD SHALL drive mem_re=1 and mem_addr=SP, then go to POP_WAIT.
REQ-023 POP_WAIT SHALL capture mem_rdata into pop_data, set SP<=inc(SP) and depth<=depth-1, pulse done, and return to IDLE.
REQ-024 Latency: a push SHALL complete with done one cycle after acceptance; a pop SHALL complete with done two cycles after acceptance.
REQ-025 If push_req and pop_req are both high in IDLE, the push SHALL win and the pop SHALL be dropped silently.
REQ-026 A push with depth==STACK_WORDS SHALL pulse overflow for one cycle and change no other state.
REQ-027 A pop with depth==0 SHALL pulse underflow for one cycle and change no other state.
REQ-028 flush in IDLE SHALL set SP<=0x0000 and depth<=0 and take priority over push_req and pop_req; no done SHALL be produced.
REQ-029 Requests arriving while busy SHALL be ignored with no error pulse.
REQ-030 Outside their active states, mem_we and mem_re SHALL be 0; mem_addr SHALL equal SP and mem_wdata SHALL be 0.

Reset
REQ-031 Reset SHALL force IDLE, SP=0x0000, depth=0, pop_data=0 and all strobes and pulses to 0, asynchronously.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no memory access, no done and no partial SP update after release.

Structure
REQ-033 Shared package stack_pkg SHALL hold SP_TOP=16'hF3FF, SP_BASE=16'h0000, the STACK_WORDS default and the FSM state encoding.
REQ-034 The step rule SHALL be a combinational sub-module, sp_step (inputs: sp, inc; output: next_sp), with one instance in stack_sequencer.

Verification
REQ-035 After reset, push 0xABCD -> PUSH_WR writes address 0xF3FF with data 0xABCD; done one cycle after acceptance; SP=0xF3FF, depth=1.
REQ-036 Pop right after REQ-035 -> mem_re at address 0xF3FF; done two cycles after acceptance; pop_data=0xABCD; SP=0x0000; depth=0.
REQ-037 Pop from empty after reset -> underflow pulse; SP, depth and pop_data unchanged; no memory strobe.
REQ-038 push_req and pop_req in the same IDLE cycle with depth=0 -> push only; depth=1; no underflow.
REQ-039 With STACK_WORDS overridden to 4: four pushes then a fifth -> the fifth pulses overflow; SP=0xF3FC; depth=4.
REQ-040 Reset asserted during POP_WAIT -> IDLE immediately; SP=0x0000, depth=0, done=0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants and FSM encoding for the descending stack sequencer.
package stack_pkg;

    localparam logic [15:0] SP_TOP              = 16'hF3FF;
    localparam logic [15:0] SP_BASE             = 16'h0000;
    localparam logic [15:0] STACK_WORDS_DEFAULT = 16'hF400;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH_WR  = 2'd1,
        POP_RD   = 2'd2,
        POP_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/stack_sequencer_sp_step.sv
// Stack pointer step with wrap at the region edges: dec(BASE)=TOP, inc(TOP)=BASE.
module sp_step
    import stack_pkg::*;
(
    input  logic [15:0] sp,
    input  logic        inc,
    output logic [15:0] next_sp
);

    always_comb begin
        next_sp = sp;
        if (inc) begin
            next_sp = (sp == SP_TOP) ? SP_BASE : sp + 16'd1;
        end else begin
            next_sp = (sp == SP_BASE) ? SP_TOP : sp - 16'd1;
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Push/pop sequencer for a descending stack in external single-port memory.
//   state    | meaning
//   IDLE     | accept flush / push / pop, flag overflow / underflow
//   PUSH_WR  | write latched word at SP (already decremented), done
//   POP_RD   | read strobe at SP
//   POP_WAIT | done; read data captured and SP incremented on exit
module stack_sequencer
    import stack_pkg::*;
#(
    parameter logic [15:0] STACK_WORDS = STACK_WORDS_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        push_req,
    input  logic        pop_req,
    input  logic        flush,
    input  logic [15:0] push_data,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] pop_data,
    output logic [15:0] SP,
    output logic [15:0] depth,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        underflow
);

    state_e      state_q;
    logic [15:0] sp_q, depth_q, pop_data_q, wdata_q;
    logic        we_q, re_q, done_q, ovf_q, unf_q;
    logic [15:0] sp_d;

    // Only POP_WAIT steps upward; IDLE uses the downward step for a push.
    sp_step u_sp_step (
        .sp      (sp_q),
        .inc     (state_q == POP_WAIT),
        .next_sp (sp_d)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            sp_q       <= SP_BASE;
            depth_q    <= 16'd0;
            pop_data_q <= 16'd0;
            wdata_q    <= 16'd0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wdata_q <= 16'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        sp_q    <= SP_BASE;
                        depth_q <= 16'd0;
                    end else if (push_req) begin
                        if (depth_q < STACK_WORDS) begin
                            sp_q    <= sp_d;
                            depth_q <= depth_q + 16'd1;
                            wdata_q <= push_data;
                            we_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= PUSH_WR;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else if (pop_req) begin
                        if (depth_q != 16'd0) begin
                            re_q    <= 1'b1;
                            state_q <= POP_RD;
                        end else begin
                            unf_q <= 1'b1;
                        end
                    end
                end
                PUSH_WR: state_q <= IDLE;
                POP_RD: begin
                    done_q  <= 1'b1;
                    state_q <= POP_WAIT;
                end
                POP_WAIT: begin
                    pop_data_q <= mem_rdata;
                    sp_q       <= sp_d;
                    depth_q    <= depth_q - 16'd1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The address always tracks SP: in PUSH_WR and POP_RD it is the target word.
    assign mem_addr  = sp_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign pop_data  = pop_data_q;
    assign SP        = sp_q;
    assign depth     = depth_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: default-size instance plus a 4-word instance.
module tb_stack_sequencer;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        push_req = 1'b0, pop_req = 1'b0, flush = 1'b0;
    logic [15:0] push_data = 16'd0;
    logic [15:0] mem_rdata = 16'd0;
    logic [15:0] mem_addr, mem_wdata, pop_data, SP, depth;
    logic        mem_we, mem_re, busy, done, overflow, underflow;

    logic [15:0] mem_rdata4 = 16'd0;
    logic [15:0] mem_addr4, mem_wdata4, pop_data4, sp4, depth4;
    logic        mem_we4, mem_re4, busy4, done4, ovf4, unf4;

    logic [15:0] mem [0:65535];
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    stack_sequencer dut (
        .CLK(CLK), .Reset(Reset), .push_req(push_req), .pop_req(pop_req), .flush(flush),
        .push_data(push_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .pop_data(pop_data), .SP(SP), .depth(depth),
        .busy(busy), .done(done), .overflow(overflow), .underflow(underflow)
    );

    stack_sequencer #(.STACK_WORDS(16'd4)) dut4 (
        .CLK(CLK), .Reset(Reset), .push_req(push_req), .pop_req(pop_req), .flush(flush),
        .push_data(push_data), .mem_rdata(mem_rdata4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_we(mem_we4), .mem_re(mem_re4), .pop_data(pop_data4), .SP(sp4), .depth(depth4),
        .busy(busy4), .done(done4), .overflow(ovf4), .underflow(unf4)
    );

    // Synchronous memory: write on mem_we, read data one cycle after mem_re.
    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        push_req = 1'b0; pop_req = 1'b0; flush = 1'b0; push_data = 16'd0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (SP !== 16'h0000) begin bad++; $display("FAIL rst_sp got=%h exp=0000", SP); end
        total++; if (depth !== 16'd0) begin bad++; $display("FAIL rst_depth got=%h exp=0000", depth); end
        total++; if (pop_data !== 16'd0) begin bad++; $display("FAIL rst_pop_data got=%h exp=0000", pop_data); end
        total++; if ({busy, done, overflow, underflow, mem_we, mem_re} !== 6'b0) begin bad++;
            $display("FAIL rst_flags got=%b exp=000000", {busy, done, overflow, underflow, mem_we, mem_re}); end
        total++; if (mem_wdata !== 16'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0000", mem_wdata); end
    endtask

    task automatic test_push_pop();
        do_reset();
        push_req = 1'b1; push_data = 16'hABCD;
        step();
        push_req = 1'b0; push_data = 16'd0;
        total++; if (mem_we !== 1'b1 || mem_addr !== 16'hF3FF || mem_wdata !== 16'hABCD) begin bad++;
            $display("FAIL push_write got we=%b addr=%h data=%h exp we=1 addr=f3ff data=abcd", mem_we, mem_addr, mem_wdata); end
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL push_done got done=%b busy=%b exp 1 1", done, busy); end
        total++; if (SP !== 16'hF3FF || depth !== 16'd1) begin bad++; $display("FAIL push_sp got sp=%h depth=%h exp f3ff 0001", SP, depth); end
        step();
        total++; if ({done, busy, mem_we} !== 3'b0 || mem_wdata !== 16'd0 || mem_addr !== 16'hF3FF) begin bad++;
            $display("FAIL push_idle got done=%b busy=%b we=%b wdata=%h addr=%h exp 0 0 0 0000 f3ff", done, busy, mem_we, mem_wdata, mem_addr); end
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        total++; if (mem_re !== 1'b1 || mem_addr !== 16'hF3FF || done !== 1'b0) begin bad++;
            $display("FAIL pop_rd got re=%b addr=%h done=%b exp 1 f3ff 0", mem_re, mem_addr, done); end
        step();
        total++; if (done !== 1'b1 || mem_re !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL pop_done got done=%b re=%b busy=%b exp 1 0 1", done, mem_re, busy); end
        step();
        total++; if (pop_data !== 16'hABCD) begin bad++; $display("FAIL pop_data got=%h exp=abcd", pop_data); end
        total++; if (SP !== 16'h0000 || depth !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL pop_final got sp=%h depth=%h done=%b busy=%b exp 0000 0000 0 0", SP, depth, done, busy); end
    endtask

    task automatic test_underflow();
        do_reset();
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_pulse got=%b exp=1", underflow); end
        total++; if (SP !== 16'h0000 || depth !== 16'd0 || pop_data !== 16'd0) begin bad++;
            $display("FAIL unf_state got sp=%h depth=%h pop=%h exp 0000 0000 0000", SP, depth, pop_data); end
        total++; if ({mem_re, mem_we, busy, done} !== 4'b0) begin bad++;
            $display("FAIL unf_strobe got=%b exp=0000", {mem_re, mem_we, busy, done}); end
        step();
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_oneshot got=%b exp=0", underflow); end
    endtask

    task automatic test_push_pop_same();
        do_reset();
        push_req = 1'b1; pop_req = 1'b1; push_data = 16'h1234;
        step();
        push_req = 1'b0; pop_req = 1'b0;
        total++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wdata !== 16'h1234 || depth !== 16'd1) begin bad++;
            $display("FAIL both_push got we=%b re=%b wdata=%h depth=%h exp 1 0 1234 0001", mem_we, mem_re, mem_wdata, depth); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL both_unf got=%b exp=0", underflow); end
        step();
        total++; if (busy !== 1'b0 || mem_re !== 1'b0 || underflow !== 1'b0) begin bad++;
            $display("FAIL both_after got busy=%b re=%b unf=%b exp 0 0 0", busy, mem_re, underflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_req = 1'b1; push_data = 16'h0100 + 16'(i);
            step();
            push_req = 1'b0;
            step();
        end
        total++; if (sp4 !== 16'hF3FC || depth4 !== 16'd4) begin bad++;
            $display("FAIL ovf_full got sp=%h depth=%h exp f3fc 0004", sp4, depth4); end
        push_req = 1'b1; push_data = 16'h0999;
        step();
        push_req = 1'b0;
        total++; if (ovf4 !== 1'b1 || mem_we4 !== 1'b0 || done4 !== 1'b0 || busy4 !== 1'b0) begin bad++;
            $display("FAIL ovf_pulse got ovf=%b we=%b done=%b busy=%b exp 1 0 0 0", ovf4, mem_we4, done4, busy4); end
        total++; if (sp4 !== 16'hF3FC || depth4 !== 16'd4) begin bad++;
            $display("FAIL ovf_state got sp=%h depth=%h exp f3fc 0004", sp4, depth4); end
        total++; if (overflow !== 1'b0 || SP !== 16'hF3FB || depth !== 16'd5) begin bad++;
            $display("FAIL ovf_big got ovf=%b sp=%h depth=%h exp 0 f3fb 0005", overflow, SP, depth); end
        step();
        total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL ovf_oneshot got=%b exp=0", ovf4); end
    endtask

    task automatic test_flush();
        flush = 1'b1; push_req = 1'b1; pop_req = 1'b1; push_data = 16'h7777;
        step();
        flush = 1'b0; push_req = 1'b0; pop_req = 1'b0;
        total++; if (SP !== 16'h0000 || depth !== 16'd0) begin bad++;
            $display("FAIL flush_state got sp=%h depth=%h exp 0000 0000", SP, depth); end
        total++; if ({done, busy, mem_we, mem_re} !== 4'b0) begin bad++;
            $display("FAIL flush_flags got=%b exp=0000", {done, busy, mem_we, mem_re}); end
    endtask

    task automatic test_back_to_back();
        push_req = 1'b1; push_data = 16'h1111; step(); push_req = 1'b0; step();
        push_req = 1'b1; push_data = 16'h2222; step(); push_req = 1'b0; step();
        total++; if (SP !== 16'hF3FE || depth !== 16'd2) begin bad++;
            $display("FAIL b2b_push got sp=%h depth=%h exp f3fe 0002", SP, depth); end
        pop_req = 1'b1; step(); pop_req = 1'b0; step(); step();
        total++; if (pop_data !== 16'h2222 || SP !== 16'hF3FF || depth !== 16'd1) begin bad++;
            $display("FAIL b2b_pop1 got pop=%h sp=%h depth=%h exp 2222 f3ff 0001", pop_data, SP, depth); end
        pop_req = 1'b1; step(); pop_req = 1'b0; step(); step();
        total++; if (pop_data !== 16'h1111 || SP !== 16'h0000 || depth !== 16'd0 || mem_addr !== 16'h0000) begin bad++;
            $display("FAIL b2b_pop2 got pop=%h sp=%h depth=%h addr=%h exp 1111 0000 0000 0000", pop_data, SP, depth, mem_addr); end
    endtask

    task automatic test_busy_ignore();
        push_req = 1'b1; push_data = 16'h5555;
        step();
        push_req = 1'b0; pop_req = 1'b1; flush = 1'b1;
        step();
        pop_req = 1'b0; flush = 1'b0;
        total++; if (depth !== 16'd1 || SP !== 16'hF3FF || busy !== 1'b0 || underflow !== 1'b0) begin bad++;
            $display("FAIL busy_ign got depth=%h sp=%h busy=%b unf=%b exp 0001 f3ff 0 0", depth, SP, busy, underflow); end
        step();
        total++; if (mem_re !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL busy_noqueue got re=%b busy=%b exp 0 0", mem_re, busy); end
    endtask

    task automatic test_reset_mid();
        pop_req = 1'b1; step(); pop_req = 1'b0; step();
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++;
            $display("FAIL mid_wait got done=%b busy=%b exp 1 1", done, busy); end
        #2 Reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || SP !== 16'h0000 || depth !== 16'd0 || done !== 1'b0) begin bad++;
            $display("FAIL mid_async got busy=%b sp=%h depth=%h done=%b exp 0 0000 0000 0", busy, SP, depth, done); end
        step();
        Reset = 1'b0;
        step();
        total++; if ({busy, done, mem_re, mem_we} !== 4'b0 || SP !== 16'h0000 || depth !== 16'd0 || pop_data !== 16'd0) begin bad++;
            $display("FAIL mid_after got flags=%b sp=%h depth=%h pop=%h exp 0000 0000 0000 0000", {busy, done, mem_re, mem_we}, SP, depth, pop_data); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_underflow();
        test_push_pop_same();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
